// File: rtl/handshake_out_fifo_if.sv
// Handshake bundle for handshake_out_fifo: upstream req_l/ack_l/din, downstream req_r/ack_r/dout.
// Statistics signals exist only when HANDSHAKE_OUT_FIFO_STATS_EN is defined.
interface handshake_out_fifo_if #(
    parameter int unsigned data_width = 32,
    parameter int unsigned depth      = 4
);
    logic                     req_l;
    logic                     ack_l;
    logic [data_width-1:0]    din;
    logic                     req_r;
    logic                     ack_r;
    logic [data_width-1:0]    dout;
    logic [$clog2(depth):0]   level;
`ifdef HANDSHAKE_OUT_FIFO_STATS_EN
    logic [31:0]              count_in;
    logic [31:0]              count_out;
    logic [$clog2(depth):0]   max_level;
`endif

    // FIFO side
    modport slave (
        output req_l,
        input  ack_l,
        input  din,
        input  req_r,
        output ack_r,
        output dout,
        output level
`ifdef HANDSHAKE_OUT_FIFO_STATS_EN
        ,
        output count_in,
        output count_out,
        output max_level
`endif
    );

    // Producer/consumer side
    modport master (
        input  req_l,
        output ack_l,
        output din,
        output req_r,
        input  ack_r,
        input  dout,
        input  level
`ifdef HANDSHAKE_OUT_FIFO_STATS_EN
        ,
        input  count_in,
        input  count_out,
        input  max_level
`endif
    );
endinterface

// File: rtl/handshake_out_fifo.sv
// Elastic buffer between a dataflow graph's out operator (requester side) and a consumer
// (responder side). Define HANDSHAKE_OUT_FIFO_STATS_EN to add transfer counters and peak level.
module handshake_out_fifo #(
    parameter int unsigned data_width = 32,
    parameter int unsigned depth      = 4
) (
    input logic                  clk,
    input logic                  rst,
    handshake_out_fifo_if.slave  bus
);
    localparam int unsigned ptr_w = $clog2(depth);
    localparam int unsigned lvl_w = ptr_w + 1;

    typedef logic [lvl_w-1:0] level_t;

    logic [data_width-1:0] mem [depth];
    logic [ptr_w-1:0]      wr_q, rd_q;
    level_t                level_q, level_d;
    logic                  req_l_q, req_l_d;
    logic                  ack_r_q;
    logic [data_width-1:0] dout_q;
    logic                  do_write, do_read;

    always_comb begin
        // An ack without an outstanding request is ignored.
        do_write = bus.ack_l && req_l_q;
        do_read  = bus.req_r && !ack_r_q && (level_q != '0);

        level_d = level_q;
        if (do_write && !do_read) begin
            level_d = level_q + 1'b1;
        end else if (!do_write && do_read) begin
            level_d = level_q - 1'b1;
        end

        // Single outstanding request, so every accepted ack has a free slot.
        req_l_d = req_l_q;
        if (do_write) begin
            req_l_d = 1'b0;
        end else if (!req_l_q && !bus.ack_l && (level_d < level_t'(depth))) begin
            req_l_d = 1'b1;
        end
    end

    // Storage is not reset; pointers and level define validity.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_q] <= bus.din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_l_q <= 1'b0;
            ack_r_q <= 1'b0;
            dout_q  <= '0;
            level_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            req_l_q <= req_l_d;
            ack_r_q <= do_read;
            level_q <= level_d;
            if (do_write) begin
                wr_q <= wr_q + 1'b1;
            end
            if (do_read) begin
                dout_q <= mem[rd_q];
                rd_q   <= rd_q + 1'b1;
            end
        end
    end

    assign bus.req_l = req_l_q;
    assign bus.ack_r = ack_r_q;
    assign bus.dout  = dout_q;
    assign bus.level = level_q;

`ifdef HANDSHAKE_OUT_FIFO_STATS_EN
    logic [31:0] count_in_q, count_out_q;
    level_t      max_level_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_in_q  <= '0;
            count_out_q <= '0;
            max_level_q <= '0;
        end else begin
            if (do_write) begin
                count_in_q <= count_in_q + 32'd1;
            end
            if (do_read) begin
                count_out_q <= count_out_q + 32'd1;
            end
            if (level_d > max_level_q) begin
                max_level_q <= level_d;
            end
        end
    end

    assign bus.count_in  = count_in_q;
    assign bus.count_out = count_out_q;
    assign bus.max_level = max_level_q;
`endif

endmodule
